// File: rtl/herzel_pkg.sv
// Shared types for the Goertzel peak picker: bin sample, bin power, FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package herzel_pkg;

    localparam int NF_DEFAULT = 7;

    typedef logic signed [31:0] bin_t;   // one Goertzel bin result
    typedef logic        [63:0] pow_t;   // exact square of a bin_t

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/bin_square.sv
// Registered squarer: pow = din*din as exact 64-bit unsigned ((-2^31)^2 = 2^62).
// Latency: 1 cycle; loads only when en is high, otherwise holds.
// Backpressure: none. Ports: clk, rstn, en, din (bin_t), pow (pow_t).
module bin_square
    import herzel_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  bin_t din,
    output pow_t pow
);

    // Sign-extend to 64 bits so the low 64 bits of the product are the exact square.
    logic signed [63:0] ext;
    assign ext = {{32{din[31]}}, din};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pow <= '0;
        end else if (en) begin
            pow <= pow_t'(ext * ext);
        end
    end

endmodule

// File: rtl/herzel_peak.sv
// Peak picker over NF Goertzel bins: captures a frame, scans bins through a squarer, reports max-power bin.
// Latency: valid_o in the cycle after edge E+NF+1 (E = IDLE->SCAN edge), i.e. NF+2 cycles.
// Backpressure: none; bins re-delivered before their frame starts set the sticky overrun_o flag.
// Ports: clk, rstn, valid_i/data_i (per-bin inputs), thresh_i, clr_i; busy_o, valid_o, peak_idx_o, peak_pow_o, detect_o, overrun_o.
module herzel_peak
    import herzel_pkg::*;
#(
    parameter int NF = NF_DEFAULT,
    parameter int IW = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NF-1:0]     valid_i,
    input  bin_t [NF-1:0]     data_i,
    input  pow_t              thresh_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [IW-1:0]     peak_idx_o,
    output pow_t              peak_pow_o,
    output logic              detect_o,
    output logic              overrun_o
);

    localparam logic [IW-1:0] LAST = IW'(NF - 1);

    state_t        state_q, state_d;
    logic [NF-1:0] pend_q;
    bin_t          cap_q  [NF];
    bin_t          work_q [NF];
    logic [IW-1:0] scan_idx_q;
    logic          start, issue, last_issue, ovr_hit;

    logic          sq_vld_q;
    logic [IW-1:0] sq_idx_q;
    pow_t          sq_pow;

    pow_t          max_pow_q, cand_pow;
    logic [IW-1:0] max_idx_q, cand_idx;
    logic          commit;

    assign start      = (state_q == ST_IDLE) && (&pend_q) && !clr_i;
    assign issue      = (state_q == ST_SCAN) && !clr_i;
    assign last_issue = issue && (scan_idx_q == LAST);
    // The edge that starts a scan consumes the frame, so a coincident valid is the next frame, not an overrun.
    assign ovr_hit    = (|(valid_i & pend_q)) && !start;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        if (clr_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (&pend_q) state_d = ST_SCAN;
                ST_SCAN:  if (scan_idx_q == LAST) state_d = ST_FLUSH;
                ST_FLUSH: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
        if (state_q == ST_SCAN || state_q == ST_FLUSH) begin
            busy_o = 1'b1;
        end
    end

    // ---------------- capture / pending / working copy ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q    <= '0;
            overrun_o <= 1'b0;
            for (int k = 0; k < NF; k++) begin
                cap_q[k]  <= '0;
                work_q[k] <= '0;
            end
        end else if (clr_i) begin
            pend_q    <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (start) begin
                for (int k = 0; k < NF; k++) begin
                    work_q[k] <= cap_q[k];
                end
            end
            for (int k = 0; k < NF; k++) begin
                if (valid_i[k]) begin
                    cap_q[k] <= data_i[k];
                end
            end
            pend_q <= (start ? {NF{1'b0}} : pend_q) | valid_i;
            if (ovr_hit) begin
                overrun_o <= 1'b1;
            end
        end
    end

    // ---------------- scan issue ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_idx_q <= '0;
            sq_vld_q   <= 1'b0;
            sq_idx_q   <= '0;
        end else begin
            if (start) begin
                scan_idx_q <= '0;
            end else if (issue && !last_issue) begin
                scan_idx_q <= scan_idx_q + 1'b1;
            end
            sq_vld_q <= issue;
            if (issue) begin
                sq_idx_q <= scan_idx_q;
            end
        end
    end

    bin_square u_sq (
        .clk  (clk),
        .rstn (rstn),
        .en   (issue),
        .din  (work_q[scan_idx_q]),
        .pow  (sq_pow)
    );

    // ---------------- compare ----------------
    // Bin 0 seeds the running max; later bins replace it only when strictly greater,
    // so ties keep the lowest index.
    always_comb begin
        cand_pow = max_pow_q;
        cand_idx = max_idx_q;
        if (sq_idx_q == '0 || sq_pow > max_pow_q) begin
            cand_pow = sq_pow;
            cand_idx = sq_idx_q;
        end
    end

    // Last bin's power is folded in combinationally and goes straight to the outputs.
    assign commit = sq_vld_q && (sq_idx_q == LAST) && !clr_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            max_pow_q  <= '0;
            max_idx_q  <= '0;
            valid_o    <= 1'b0;
            peak_idx_o <= '0;
            peak_pow_o <= '0;
            detect_o   <= 1'b0;
        end else begin
            if (sq_vld_q) begin
                max_pow_q <= cand_pow;
                max_idx_q <= cand_idx;
            end
            valid_o <= commit;
            if (commit) begin
                peak_idx_o <= cand_idx;
                peak_pow_o <= cand_pow;
                detect_o   <= (cand_pow > thresh_i);
            end
        end
    end

endmodule

// File: tb/tb_herzel_peak.sv
// Self-checking bench for herzel_peak: directed scenarios plus randomized traffic against a frame-level model.
module tb_herzel_peak;

    localparam int NF = 7;
    localparam int IW = 3;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NF-1:0]        valid_i = '0;
    logic [NF-1:0][31:0]  data_i = '0;
    logic [63:0]          thresh_i = '0;
    logic                 clr_i = 1'b0;
    logic                 busy_o, valid_o, detect_o, overrun_o;
    logic [IW-1:0]        peak_idx_o;
    logic [63:0]          peak_pow_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    herzel_peak #(.NF(NF)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .thresh_i   (thresh_i),
        .clr_i      (clr_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .peak_idx_o (peak_idx_o),
        .peak_pow_o (peak_pow_o),
        .detect_o   (detect_o),
        .overrun_o  (overrun_o)
    );

    // ---------------- reference model (frame level) ----------------
    // A frame starts when the block is idle and every bin has arrived; it keeps the
    // block busy for NF+1 cycles and publishes its result at the edge NF+1 after the start.
    int              cyc = 0;
    bit              m_pend [NF];
    int              m_cap  [NF];
    longint unsigned m_sq   [NF];
    int              m_busy = 0;
    bit              m_inflight = 0;
    int              m_commit_at = 0;
    int              m_ridx = 0;
    longint unsigned m_rpow = 0;
    bit              m_valid = 0, m_det = 0, m_ovr = 0, m_start = 0, m_all = 0;
    int              m_idx = 0;
    longint unsigned m_pow = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        m_valid = 0;
        if (!rstn) begin
            for (int k = 0; k < NF; k++) begin m_pend[k] = 0; m_cap[k] = 0; end
            m_busy = 0; m_inflight = 0; m_det = 0; m_ovr = 0; m_idx = 0; m_pow = 0;
        end else if (clr_i) begin
            for (int k = 0; k < NF; k++) m_pend[k] = 0;
            m_busy = 0; m_inflight = 0; m_ovr = 0;
        end else begin
            m_start = 0;
            if (m_inflight && cyc == m_commit_at) begin
                m_idx = m_ridx; m_pow = m_rpow; m_det = (m_rpow > thresh_i);
                m_valid = 1; m_inflight = 0;
            end
            m_all = 1;
            for (int k = 0; k < NF; k++) if (!m_pend[k]) m_all = 0;
            if (m_busy > 0) m_busy--;
            else if (m_all) m_start = 1;
            if (m_start) begin
                m_rpow = 0;
                for (int k = 0; k < NF; k++) begin
                    m_sq[k] = longint'(m_cap[k]) * longint'(m_cap[k]);
                    if (m_sq[k] > m_rpow) m_rpow = m_sq[k];
                end
                m_ridx = 0;
                for (int k = NF - 1; k >= 0; k--) if (m_sq[k] == m_rpow) m_ridx = k;
                m_inflight = 1; m_commit_at = cyc + NF + 1; m_busy = NF + 1;
                for (int k = 0; k < NF; k++) m_pend[k] = 0;
            end
            for (int k = 0; k < NF; k++) begin
                if (valid_i[k]) begin
                    if (m_pend[k]) m_ovr = 1;
                    m_cap[k] = int'(data_i[k]);
                    m_pend[k] = 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int fr [NF];
    int tbl [5][NF] = '{'{3, -10, 4, 0, 9, -2, 1},
                        '{5, -5, 0, 0, 0, 0, 0},
                        '{int'(32'h8000_0000), 0, 0, 0, 0, 0, 0},
                        '{0, 0, 0, 0, 0, 0, 0},
                        '{1, 2, 3, 4, 5, 6, -7}};
    longint unsigned tth  [5] = '{50, 25, 0, 0, 49};
    int              tidx [5] = '{1, 0, 0, 0, 6};
    longint unsigned tpow [5] = '{100, 25, 64'h4000_0000_0000_0000, 0, 49};
    bit              tdet [5] = '{1, 0, 1, 0, 0};

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k, input int v);
        valid_i = '0;
        valid_i[k] = 1'b1;
        data_i[k] = v;
        align();
        valid_i = '0;
    endtask

    // One bin per cycle from fr[]; returns just after the edge that loads the last bin.
    task automatic deliver();
        for (int k = 0; k < NF; k++) pulse(k, fr[k]);
    endtask

    task automatic wait_valid(input int limit, output bit seen, output int at, output int nbusy);
        seen = 0; at = -1; nbusy = 0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin seen = 1; at = cyc; end
            else if (busy_o === 1'b1) nbusy++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (valid_o !== 1'b0)     begin n_fail++; $display("FAIL rst_valid got %b exp 0", valid_o); end
        n_chk++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy_o); end
        n_chk++; if (peak_idx_o !== 3'd0)  begin n_fail++; $display("FAIL rst_idx got %0d exp 0", peak_idx_o); end
        n_chk++; if (peak_pow_o !== 64'd0) begin n_fail++; $display("FAIL rst_pow got %0d exp 0", peak_pow_o); end
        n_chk++; if (detect_o !== 1'b0)    begin n_fail++; $display("FAIL rst_det got %b exp 0", detect_o); end
        n_chk++; if (overrun_o !== 1'b0)   begin n_fail++; $display("FAIL rst_ovr got %b exp 0", overrun_o); end
        rstn = 1'b1;
        align();
    endtask

    task automatic test_peak();
        bit seen; int at, nb, c0;
        for (int i = 0; i < 5; i++) begin
            thresh_i = tth[i];
            fr = tbl[i];
            deliver();
            c0 = cyc;
            wait_valid(30, seen, at, nb);
            n_chk++; if (!seen) begin n_fail++; $display("FAIL peak%0d_seen got 0 exp 1", i); end
            n_chk++; if (at != c0 + NF + 2) begin n_fail++; $display("FAIL peak%0d_lat got %0d exp %0d", i, at - c0, NF + 2); end
            n_chk++; if (nb != NF + 1) begin n_fail++; $display("FAIL peak%0d_busy got %0d exp %0d", i, nb, NF + 1); end
            n_chk++; if (peak_idx_o !== 3'(tidx[i])) begin n_fail++; $display("FAIL peak%0d_idx got %0d exp %0d", i, peak_idx_o, tidx[i]); end
            n_chk++; if (peak_pow_o !== tpow[i]) begin n_fail++; $display("FAIL peak%0d_pow got %0d exp %0d", i, peak_pow_o, tpow[i]); end
            n_chk++; if (detect_o !== tdet[i]) begin n_fail++; $display("FAIL peak%0d_det got %b exp %b", i, detect_o, tdet[i]); end
            @(negedge clk);
            n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL peak%0d_pulse got %b exp 0", i, valid_o); end
            n_chk++; if (peak_pow_o !== tpow[i]) begin n_fail++; $display("FAIL peak%0d_hold got %0d exp %0d", i, peak_pow_o, tpow[i]); end
            align();
        end
    endtask

    task automatic test_overrun_clear();
        bit seen; int at, nb;
        thresh_i = 64'd0;
        n_chk++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_init got %b exp 0", overrun_o); end
        pulse(0, 1); pulse(1, 1); pulse(2, 11); pulse(2, -20);
        n_chk++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b exp 1", overrun_o); end
        for (int k = 3; k < NF; k++) pulse(k, 1);
        wait_valid(30, seen, at, nb);
        n_chk++; if (!seen) begin n_fail++; $display("FAIL ovr_seen got 0 exp 1"); end
        n_chk++; if (peak_idx_o !== 3'd2) begin n_fail++; $display("FAIL ovr_idx got %0d exp 2", peak_idx_o); end
        n_chk++; if (peak_pow_o !== 64'd400) begin n_fail++; $display("FAIL ovr_pow got %0d exp 400", peak_pow_o); end
        n_chk++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b exp 1", overrun_o); end
        align();
        // Partial frame, then clear: pending must be flushed.
        for (int k = 0; k < 4; k++) pulse(k, 5);
        clr_i = 1'b1; align(); clr_i = 1'b0;
        n_chk++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL clr_ovr got %b exp 0", overrun_o); end
        for (int k = 4; k < NF; k++) pulse(k, 5);
        wait_valid(20, seen, at, nb);
        n_chk++; if (seen) begin n_fail++; $display("FAIL clr_flush got valid exp none"); end
        n_chk++; if (nb != 0) begin n_fail++; $display("FAIL clr_busy got %0d exp 0", nb); end
        align();
        clr_i = 1'b1; align(); clr_i = 1'b0;
        // Clear in the middle of a scan aborts it and holds the old result.
        fr = '{9, 8, 7, 6, 5, 4, 3};
        deliver();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy_pre got %b exp 1", busy_o); end
        clr_i = 1'b1; align(); clr_i = 1'b0;
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy_o); end
        wait_valid(20, seen, at, nb);
        n_chk++; if (seen) begin n_fail++; $display("FAIL abort_valid got valid exp none"); end
        n_chk++; if (peak_pow_o !== 64'd400) begin n_fail++; $display("FAIL abort_hold got %0d exp 400", peak_pow_o); end
        align();
    endtask

    task automatic test_back_to_back();
        bit s1, s2; int a1, a2, nb, c1;
        thresh_i = 64'd50;
        fr = '{1, 2, 3, 4, 5, 6, 0};
        deliver();
        c1 = cyc;
        fr = '{7, 7, 7, 7, 7, 7, 8};
        deliver();
        n_chk++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr got %b exp 0", overrun_o); end
        wait_valid(30, s1, a1, nb);
        n_chk++; if (!s1) begin n_fail++; $display("FAIL b2b_seen1 got 0 exp 1"); end
        n_chk++; if (a1 != c1 + NF + 2) begin n_fail++; $display("FAIL b2b_lat1 got %0d exp %0d", a1 - c1, NF + 2); end
        n_chk++; if (peak_idx_o !== 3'd5 || peak_pow_o !== 64'd36 || detect_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_res1 got %0d/%0d/%b exp 5/36/0", peak_idx_o, peak_pow_o, detect_o); end
        wait_valid(30, s2, a2, nb);
        n_chk++; if (!s2) begin n_fail++; $display("FAIL b2b_seen2 got 0 exp 1"); end
        n_chk++; if (a2 != c1 + 2 * (NF + 2)) begin n_fail++; $display("FAIL b2b_lat2 got %0d exp %0d", a2 - c1, 2 * (NF + 2)); end
        n_chk++; if (peak_idx_o !== 3'd6 || peak_pow_o !== 64'd64 || detect_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_res2 got %0d/%0d/%b exp 6/64/1", peak_idx_o, peak_pow_o, detect_o); end
        align();
    endtask

    task automatic test_reset_midscan();
        bit seen; int at, nb, c0;
        thresh_i = 64'd50;
        fr = tbl[0];
        deliver();
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        n_chk++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            n_fail++; $display("FAIL mrst_flags got v%b b%b o%b exp 000", valid_o, busy_o, overrun_o); end
        n_chk++; if (peak_idx_o !== 3'd0 || peak_pow_o !== 64'd0 || detect_o !== 1'b0) begin
            n_fail++; $display("FAIL mrst_peak got %0d/%0d/%b exp 0/0/0", peak_idx_o, peak_pow_o, detect_o); end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        wait_valid(20, seen, at, nb);
        n_chk++; if (seen) begin n_fail++; $display("FAIL mrst_valid got valid exp none"); end
        align();
        fr = tbl[0];
        deliver();
        c0 = cyc;
        wait_valid(30, seen, at, nb);
        n_chk++; if (!seen || at != c0 + NF + 2) begin n_fail++; $display("FAIL mrst_after_lat got %0d exp %0d", at - c0, NF + 2); end
        n_chk++; if (peak_idx_o !== 3'd1 || peak_pow_o !== 64'd100 || detect_o !== 1'b1) begin
            n_fail++; $display("FAIL mrst_after_res got %0d/%0d/%b exp 1/100/1", peak_idx_o, peak_pow_o, detect_o); end
        align();
    endtask

    task automatic test_random();
        int nres = 0;
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < NF; k++) begin
                valid_i[k] = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0:       data_i[k] = $urandom();
                    1:       data_i[k] = 32'h8000_0000;
                    default: data_i[k] = 32'($urandom_range(0, 40)) - 32'd20;
                endcase
            end
            clr_i = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) thresh_i = 64'($urandom_range(0, 500));
            @(negedge clk);
            n_chk++; if (valid_o !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %b exp %b", c, valid_o, m_valid); end
            n_chk++; if (busy_o !== (m_busy > 0)) begin n_fail++; $display("FAIL rnd_busy c%0d got %b exp %b", c, busy_o, m_busy > 0); end
            n_chk++; if (overrun_o !== m_ovr) begin n_fail++; $display("FAIL rnd_ovr c%0d got %b exp %b", c, overrun_o, m_ovr); end
            n_chk++; if (peak_idx_o !== 3'(m_idx)) begin n_fail++; $display("FAIL rnd_idx c%0d got %0d exp %0d", c, peak_idx_o, m_idx); end
            n_chk++; if (peak_pow_o !== m_pow) begin n_fail++; $display("FAIL rnd_pow c%0d got %0d exp %0d", c, peak_pow_o, m_pow); end
            n_chk++; if (detect_o !== m_det) begin n_fail++; $display("FAIL rnd_det c%0d got %b exp %b", c, detect_o, m_det); end
            if (valid_o === 1'b1) nres++;
            align();
        end
        valid_i = '0;
        clr_i = 1'b0;
        n_chk++; if (nres == 0) begin n_fail++; $display("FAIL rnd_results got 0 exp >0"); end
    endtask

    initial begin
        test_reset();
        test_peak();
        test_overrun_clear();
        test_back_to_back();
        test_reset_midscan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/herzel_peak.md
HERZEL_PEAK -- requirements
Module: herzel_peak

Interface
REQ-001 The block SHALL have parameter NF, default 7, giving the number of Goertzel bins.
REQ-002 The block SHALL have parameter IW, default max(1, clog2(NF)), giving the bin-index width (3 for NF=7).
REQ-003 Port clk, input, 1: the single clock; every flop is clocked on its rising edge.
REQ-004 Port rstn, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port valid_i, input, NF: per-bin one-cycle pulse marking that bin k's result is ready.
REQ-006 Port data_i, input, NF x 32 signed: per-bin Goertzel result, sampled when valid_i[k] is high.
REQ-007 Port thresh_i, input, 64 unsigned: detection threshold, quasi-static.
REQ-008 Port clr_i, input, 1: synchronous clear; flushes the pending frame, aborts any scan and clears overrun_o.
REQ-009 Port busy_o, output, 1: high while the state is SCAN or FLUSH.
REQ-010 Port valid_o, output, 1: one-cycle pulse marking that the peak outputs have been updated.
REQ-011 Port peak_idx_o, output, IW: index of the bin with maximum power.
REQ-012 Port peak_pow_o, output, 64 unsigned: power of that bin.
REQ-013 Port detect_o, output, 1: high when peak_pow_o > thresh_i, evaluated at the update.
REQ-014 Port overrun_o, output, 1: sticky flag; set when a bin is re-delivered before its frame was consumed.

Function
REQ-015 Each bin k SHALL have a capture register and a pending bit; valid_i[k] loads data_i[k] into the capture register and sets pending[k].
REQ-016 valid_i[k] arriving while pending[k] is already set SHALL overwrite the capture register and set overrun_o.
REQ-017 The state machine SHALL have states IDLE, SCAN and FLUSH; reset state is IDLE.
REQ-018 IDLE -> SCAN SHALL occur on the edge where state is IDLE, all pending bits are set and clr_i=0; that edge copies the captures into working registers, clears all pending bits and sets the scan index to 0.
REQ-019 A valid_i pulse coincident with the IDLE -> SCAN edge SHALL set pending for the next frame, not be lost.
REQ-020 If the frame completes while the state is not IDLE, the start SHALL wait (pending bits held) until the state returns to IDLE.
REQ-021 SCAN SHALL issue one bin per cycle, index 0..NF-1, into a registered squarer computing data*data as 64-bit unsigned (exact; (-2^31)^2 = 2^62).
REQ-022 The compare stage SHALL replace the running maximum only if the new power is strictly greater; ties therefore keep the lowest index.
REQ-023 SCAN -> FLUSH SHALL occur after index NF-1 is issued; FLUSH -> IDLE SHALL occur after one cycle.
REQ-024 peak_idx_o, peak_pow_o and detect_o SHALL be registered, updated on the edge that asserts valid_o, and held until the next update.
REQ-025 With E the IDLE -> SCAN edge, valid_o SHALL be high for exactly the cycle following edge E+NF+1, which is latency NF+2.
REQ-026 clr_i SHALL take priority over all other events: next state IDLE, pending and overrun cleared, no valid_o, peak outputs held.
REQ-027 An all-zero frame SHALL yield peak_idx_o=0, peak_pow_o=0, and detect_o=1 only if thresh_i is 0 is false, i.e. detect_o=0 since 0 > 0 is false.

Reset
REQ-028 rstn low SHALL force IDLE, clear pending, working and capture registers, and drive every output to 0.
REQ-029 Reset mid-scan SHALL abort the scan with no valid_o.

Structure
REQ-030 Types bin_t (signed 32) and pow_t (unsigned 64) and the default NF SHALL live in the shared package herzel_pkg.
REQ-031 The registered squarer SHALL be the single sub-module bin_square (one-cycle latency).

Verification
REQ-032 NF=7, bins {3,-10,4,0,9,-2,1} delivered one per cycle, thresh=50 -> after NF+2 cycles valid_o, peak_idx_o=1, peak_pow_o=100, detect_o=1.
REQ-033 Bins {5,-5,0,0,0,0,0}, thresh=25 -> peak_idx_o=0 (tie), peak_pow_o=25, detect_o=0.
REQ-034 Bin 0 = -2^31, others 0 -> peak_pow_o=2^62, peak_idx_o=0.
REQ-035 valid_i[2] pulsed twice before frame complete -> overrun_o=1 with second value used; clr_i -> overrun_o=0, pending cleared, no valid_o.
REQ-036 Second full frame delivered during SCAN, bins all 7 except bin 6 = 8 -> first result on time, second SCAN starts on the FLUSH -> IDLE return, second result peak_idx_o=6, peak_pow_o=64.
REQ-037 rstn low at SCAN index 3 -> all outputs 0, no valid_o; following full frame processes normally.
